ibis_tmds_channel: RTL and testbench

One TMDS lane encoder and 10:2 serializer for the Ibis DVI/HDMI output path. It sits directly downstream of `ibis_vga_timing` and takes one pixel byte or one control pair per pixel period. It produces DVI 1.0 transition-minimised, DC-balanced 10-bit symbols and shifts them out two bits per TMDS-domain `aclk` for a DDR output primitive. Three instances are used, one per colour channel; channel 0 carries hsync/vsync as its control pair.

---
 rtl/ibis_tmds_pkg.sv | 22 ++
 rtl/ibis_tmds_encode.sv | 130 +++++++++++++
 rtl/ibis_tmds_channel.sv | 94 +++++++++
 tb/tb_ibis_tmds_channel.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibis_tmds_pkg.sv
// ibis_tmds_pkg
//   Shared types, control-symbol constants and helpers for the Ibis TMDS
//   lane encoder (ibis_tmds_encode) and serializer (ibis_tmds_channel).
package ibis_tmds_pkg;

   typedef logic signed [4:0] tmds_disparity_t;
   typedef logic [9:0]        tmds_symbol_t;

   // Control symbols for {c1,c0} during blanking
   localparam tmds_symbol_t TMDS_CTRL_00 = 10'h354;
   localparam tmds_symbol_t TMDS_CTRL_01 = 10'h0AB;
   localparam tmds_symbol_t TMDS_CTRL_10 = 10'h154;
   localparam tmds_symbol_t TMDS_CTRL_11 = 10'h2AB;

   function automatic logic [3:0] tmds_popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
      return n;
   endfunction

endpackage

// File: rtl/ibis_tmds_encode.sv
// ibis_tmds_encode
//   Two-stage DVI 1.0 TMDS encoder for one lane.
//   S1: captures de/ctrl and the transition-minimised q_m[8:0] plus its
//       ones count on an enabled pixel strobe.
//   S2: applies the DC-balance rules (or selects a control symbol) and
//       keeps the running disparity cnt.
// Ports:
//   aclk, areset      clock, synchronous active-high reset
//   enable            global clock enable (all state holds while low)
//   pixel_stb         pixel-period strobe
//   de, data, ctrl    pixel byte / control pair, sampled on enable & pixel_stb
//   sym, sym_vld      S2 symbol and its valid flag (valid for one enabled cycle)
//   sym_pulse         (IBIS_TMDS_PARALLEL_OUT_EN) 1-aclk pulse when S2 updates
//   disparity         (IBIS_TMDS_PARALLEL_OUT_EN) running disparity cnt
module ibis_tmds_encode
   import ibis_tmds_pkg::*;
(
   input  logic          aclk,
   input  logic          areset,
   input  logic          enable,
   input  logic          pixel_stb,
   input  logic          de,
   input  logic [7:0]    data,
   input  logic [1:0]    ctrl,
   output tmds_symbol_t  sym,
   output logic          sym_vld
`ifdef IBIS_TMDS_PARALLEL_OUT_EN
   ,
   output logic            sym_pulse,
   output tmds_disparity_t disparity
`endif
);

   // ---------------- S1 ----------------
   logic [3:0] n1_data;
   logic       use_xnor;
   logic [8:0] qm_d;
   logic       q;

   always_comb begin
      n1_data  = tmds_popcount8(data);
      use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data[0]);
      qm_d     = '0;
      q        = data[0];
      qm_d[0]  = q;
      for (int i = 1; i < 8; i++) begin
         q       = use_xnor ? ~(q ^ data[i]) : (q ^ data[i]);
         qm_d[i] = q;
      end
      qm_d[8] = ~use_xnor;
   end

   logic       s1_vld;
   logic       s1_de;
   logic [1:0] s1_ctrl;
   logic [8:0] s1_qm;
   logic [3:0] s1_n1;

   // ---------------- S2 ----------------
   tmds_disparity_t cnt;
   tmds_disparity_t cnt_d;
   tmds_disparity_t dpos;     // N1 - N0 of q_m[7:0]
   tmds_disparity_t two_q8;   // 2*q_m[8]
   tmds_disparity_t two_nq8;  // 2*~q_m[8]
   tmds_symbol_t    sym_d;

   always_comb begin
      // N1 - N0 = 2*N1 - 8; all cnt arithmetic wraps modulo 32
      dpos    = $signed({s1_n1, 1'b0}) - 5'sd8;
      two_q8  = {3'b000, s1_qm[8], 1'b0};
      two_nq8 = {3'b000, ~s1_qm[8], 1'b0};
      sym_d   = '0;
      cnt_d   = cnt;
      if (!s1_de) begin
         cnt_d = '0;
         case (s1_ctrl)
            2'b00:   sym_d = TMDS_CTRL_00;
            2'b01:   sym_d = TMDS_CTRL_01;
            2'b10:   sym_d = TMDS_CTRL_10;
            default: sym_d = TMDS_CTRL_11;
         endcase
      end else if ((cnt == '0) || (s1_n1 == 4'd4)) begin
         sym_d = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
         cnt_d = s1_qm[8] ? (cnt + dpos) : (cnt - dpos);
      end else if ((!cnt[4] && (s1_n1 > 4'd4)) || (cnt[4] && (s1_n1 < 4'd4))) begin
         // symbol would push disparity further the same way: invert
         sym_d = {1'b1, s1_qm[8], ~s1_qm[7:0]};
         cnt_d = cnt + two_q8 - dpos;
      end else begin
         sym_d = {1'b0, s1_qm[8], s1_qm[7:0]};
         cnt_d = cnt - two_nq8 + dpos;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         s1_vld  <= 1'b0;
         s1_de   <= 1'b0;
         s1_ctrl <= '0;
         s1_qm   <= '0;
         s1_n1   <= '0;
         sym     <= '0;
         sym_vld <= 1'b0;
         cnt     <= '0;
      end else if (enable) begin
         s1_vld <= pixel_stb;
         if (pixel_stb) begin
            s1_de   <= de;
            s1_ctrl <= ctrl;
            s1_qm   <= qm_d;
            s1_n1   <= tmds_popcount8(qm_d[7:0]);
         end
         sym_vld <= s1_vld;
         if (s1_vld) begin
            sym <= sym_d;
            cnt <= cnt_d;
         end
      end
   end

`ifdef IBIS_TMDS_PARALLEL_OUT_EN
   // sym_vld can stretch across enable-low cycles; this is a true 1-aclk pulse
   always_ff @(posedge aclk) begin
      if (areset) sym_pulse <= 1'b0;
      else        sym_pulse <= enable & s1_vld;
   end
   assign disparity = cnt;
`endif

endmodule

// File: rtl/ibis_tmds_channel.sv
// ibis_tmds_channel
//   One TMDS lane: encoder (ibis_tmds_encode) plus 10:2 serializer with
//   framing-error detection. Optional parallel debug outputs are built when
//   IBIS_TMDS_PARALLEL_OUT_EN is defined.
// Ports:
//   aclk, areset      TMDS-domain clock, synchronous active-high reset
//   enable            global clock enable
//   pixel_stb         pixel-period strobe (one enabled cycle in 5)
//   de, data, ctrl    pixel byte / control pair
//   tmds_pair         serial pair, bit 0 transmitted first
//   sym_err           sticky framing error (underrun or early load)
//   sym_out, sym_vld, disparity   (IBIS_TMDS_PARALLEL_OUT_EN) S2 symbol,
//                     1-cycle update pulse, running disparity
module ibis_tmds_channel
   import ibis_tmds_pkg::*;
(
   input  logic       aclk,
   input  logic       areset,
   input  logic       enable,
   input  logic       pixel_stb,
   input  logic       de,
   input  logic [7:0] data,
   input  logic [1:0] ctrl,
   output logic [1:0] tmds_pair,
   output logic       sym_err
`ifdef IBIS_TMDS_PARALLEL_OUT_EN
   ,
   output logic [9:0] sym_out,
   output logic       sym_vld,
   output logic [4:0] disparity
`endif
);

   tmds_symbol_t enc_sym;
   logic         enc_vld;

`ifdef IBIS_TMDS_PARALLEL_OUT_EN
   tmds_disparity_t enc_disp;
`endif

   ibis_tmds_encode u_enc (
      .aclk      (aclk),
      .areset    (areset),
      .enable    (enable),
      .pixel_stb (pixel_stb),
      .de        (de),
      .data      (data),
      .ctrl      (ctrl),
      .sym       (enc_sym),
      .sym_vld   (enc_vld)
`ifdef IBIS_TMDS_PARALLEL_OUT_EN
      ,
      .sym_pulse (sym_vld),
      .disparity (enc_disp)
`endif
   );

`ifdef IBIS_TMDS_PARALLEL_OUT_EN
   assign sym_out   = enc_sym;
   assign disparity = enc_disp;
`endif

   // Serializer: sreg[1:0] is always the pair on the wire. After the fourth
   // shift it holds symbol[9:8], so an underrun naturally repeats those bits.
   tmds_symbol_t sreg;
   logic [2:0]   phase;
   logic         primed;   // a symbol has been loaded since reset

   always_ff @(posedge aclk) begin
      if (areset) begin
         sreg    <= '0;
         phase   <= 3'd0;
         primed  <= 1'b0;
         sym_err <= 1'b0;
      end else if (enable) begin
         if (enc_vld) begin
            sreg   <= enc_sym;
            phase  <= 3'd0;
            primed <= 1'b1;
            // early load: previous symbol not fully sent
            if (primed && (phase != 3'd4)) sym_err <= 1'b1;
         end else if (phase != 3'd4) begin
            sreg  <= {2'b00, sreg[9:2]};
            phase <= phase + 3'd1;
         end else if (primed) begin
            // underrun: hold phase 4, keep repeating symbol[9:8]
            sym_err <= 1'b1;
         end
      end
   end

   assign tmds_pair = sreg[1:0];

endmodule

// File: tb/tb_ibis_tmds_channel.sv
module tb_ibis_tmds_channel;

   logic       aclk = 1'b0;
   logic       areset;
   logic       enable;
   logic       pixel_stb;
   logic       de;
   logic [7:0] data;
   logic [1:0] ctrl;
   logic [1:0] tmds_pair;
   logic       sym_err;

   int n_cmp = 0;
   int n_bad = 0;
   int model_cnt = 0;

   logic       pix_de   [0:63];
   logic [7:0] pix_data [0:63];
   logic [1:0] pix_ctrl [0:63];
   logic [9:0] got      [0:63];
   logic [9:0] exp_sym  [0:63];

   ibis_tmds_channel dut (
      .aclk      (aclk),
      .areset    (areset),
      .enable    (enable),
      .pixel_stb (pixel_stb),
      .de        (de),
      .data      (data),
      .ctrl      (ctrl),
      .tmds_pair (tmds_pair),
      .sym_err   (sym_err)
   );

   always #5 aclk = ~aclk;

   // Reference: DVI 1.0 encoding rules written with integer arithmetic.
   function automatic logic [9:0] ref_sym(input logic de_i, input logic [7:0] d, input logic [1:0] c);
      int ones, n1, n0, nc;
      logic xn, q8;
      logic [7:0] qm;
      logic [9:0] s;
      if (!de_i) begin
         model_cnt = 0;
         case (c)
            2'b00: return 10'h354;
            2'b01: return 10'h0AB;
            2'b10: return 10'h154;
            default: return 10'h2AB;
         endcase
      end
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      q8 = !xn;
      n1 = 0;
      for (int i = 0; i < 8; i++) n1 += int'(qm[i]);
      n0 = 8 - n1;
      nc = model_cnt;
      if (nc == 0 || n1 == n0) begin
         s = {!q8, q8, q8 ? qm : ~qm};
         nc = q8 ? nc + (n1 - n0) : nc + (n0 - n1);
      end else if ((nc > 0 && n1 > n0) || (nc < 0 && n0 > n1)) begin
         s = {1'b1, q8, ~qm};
         nc = nc + 2 * int'(q8) + (n0 - n1);
      end else begin
         s = {1'b0, q8, qm};
         nc = nc - 2 * int'(!q8) + (n1 - n0);
      end
      model_cnt = ((nc + 16) % 32 + 32) % 32 - 16;  // 5-bit signed wrap
      return s;
   endfunction

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic do_reset();
      areset = 1'b1; enable = 1'b1; pixel_stb = 1'b0;
      de = 1'b0; data = '0; ctrl = '0;
      tick(); tick();
      areset = 1'b0;
      model_cnt = 0;
   endtask

   // Drive n pixels with strobes every 5 enabled cycles; assemble the pairs
   // observed after each load edge back into 10-bit words in got[].
   task automatic stream(input int n);
      for (int c = 0; c <= 5 * n + 1; c++) begin
         pixel_stb = (c % 5 == 0) && (c / 5 < n);
         if (pixel_stb) begin
            de = pix_de[c/5]; data = pix_data[c/5]; ctrl = pix_ctrl[c/5];
         end
         tick();
         pixel_stb = 1'b0;
         if (c >= 2 && (c - 2) / 5 < n) got[(c-2)/5][2*((c-2)%5) +: 2] = tmds_pair;
      end
   endtask

   task automatic test_reset();
      areset = 1'b1; enable = 1'b1; pixel_stb = 1'b0; de = 1'b1; data = 8'hA5; ctrl = 2'b11;
      tick(); tick();
      areset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         data = 8'($urandom);
         tick();
         n_cmp++;
         if (tmds_pair !== 2'b00 || sym_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle[%0d]: pair=%b err=%b want pair=00 err=0", i, tmds_pair, sym_err);
         end
      end
   endtask

   task automatic test_data_00();
      do_reset();
      for (int i = 0; i < 2; i++) begin pix_de[i] = 1'b1; pix_data[i] = 8'h00; pix_ctrl[i] = 2'b00; end
      stream(2);
      n_cmp++;
      if (got[0] !== 10'h100) begin n_bad++; $display("FAIL data00_sym0: got %h want 100", got[0]); end
      n_cmp++;
      if (got[1] !== 10'h3FF) begin n_bad++; $display("FAIL data00_sym1: got %h want 3ff", got[1]); end
      n_cmp++;
      if (sym_err !== 1'b0) begin n_bad++; $display("FAIL data00_err: got %b want 0", sym_err); end
   endtask

   task automatic test_data_ff();
      do_reset();
      pix_de[0] = 1'b1; pix_data[0] = 8'hFF; pix_ctrl[0] = 2'b00;
      // a following 0x00 sees cnt = -8 and must be inverted
      pix_de[1] = 1'b1; pix_data[1] = 8'h00; pix_ctrl[1] = 2'b00;
      stream(2);
      n_cmp++;
      if (got[0] !== 10'h200) begin n_bad++; $display("FAIL dataff_sym: got %h want 200", got[0]); end
      n_cmp++;
      if (got[1] !== 10'h3FF) begin n_bad++; $display("FAIL dataff_cnt_neg8: got %h want 3ff", got[1]); end
   endtask

   task automatic test_control();
      logic [9:0] want [0:5];
      want[0] = 10'h100; want[1] = 10'h354; want[2] = 10'h0AB;
      want[3] = 10'h154; want[4] = 10'h2AB; want[5] = 10'h100;
      do_reset();
      pix_de[0] = 1'b1; pix_data[0] = 8'h00; pix_ctrl[0] = 2'b00;
      for (int i = 1; i < 5; i++) begin pix_de[i] = 1'b0; pix_data[i] = 8'($urandom); pix_ctrl[i] = 2'(i - 1); end
      pix_de[5] = 1'b1; pix_data[5] = 8'h00; pix_ctrl[5] = 2'b00;
      stream(6);
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (got[i] !== want[i]) begin n_bad++; $display("FAIL control_sym[%0d]: got %h want %h", i, got[i], want[i]); end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 40; i++) begin
         pix_de[i]   = ($urandom_range(0, 7) != 0);
         pix_data[i] = 8'($urandom);
         pix_ctrl[i] = 2'($urandom);
         exp_sym[i]  = ref_sym(pix_de[i], pix_data[i], pix_ctrl[i]);
      end
      stream(40);
      for (int i = 0; i < 40; i++) begin
         n_cmp++;
         if (got[i] !== exp_sym[i]) begin
            n_bad++;
            $display("FAIL random_sym[%0d]: got %h want %h (de=%b data=%h ctrl=%b)", i, got[i], exp_sym[i], pix_de[i], pix_data[i], pix_ctrl[i]);
         end
      end
      n_cmp++;
      if (sym_err !== 1'b0) begin n_bad++; $display("FAIL random_err: got %b want 0", sym_err); end
   endtask

   task automatic test_underrun();
      logic [9:0] e;
      do_reset();
      pix_de[0] = 1'b1; pix_data[0] = 8'($urandom); pix_ctrl[0] = 2'b00;
      e = ref_sym(1'b1, pix_data[0], 2'b00);
      stream(1);
      n_cmp++;
      if (got[0] !== e) begin n_bad++; $display("FAIL underrun_sym: got %h want %h", got[0], e); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (tmds_pair !== e[9:8] || sym_err !== 1'b1) begin
            n_bad++;
            $display("FAIL underrun_hold[%0d]: pair=%b err=%b want pair=%b err=1", i, tmds_pair, sym_err, e[9:8]);
         end
      end
   endtask

   task automatic test_early();
      logic [9:0] ea, eb, gb;
      logic [7:0] da, db;
      do_reset();
      da = 8'($urandom); db = 8'($urandom);
      ea = ref_sym(1'b1, da, 2'b00);
      eb = ref_sym(1'b1, db, 2'b00);
      de = 1'b1; data = da; pixel_stb = 1'b1; tick();      // E0: A
      pixel_stb = 1'b0; tick();
      data = db; pixel_stb = 1'b1; tick();                  // load A; strobe B 3 cycles early
      pixel_stb = 1'b0;
      n_cmp++;
      if (tmds_pair !== ea[1:0]) begin n_bad++; $display("FAIL early_a0: got %b want %b", tmds_pair, ea[1:0]); end
      tick();
      n_cmp++;
      if (tmds_pair !== ea[3:2] || sym_err !== 1'b0) begin
         n_bad++; $display("FAIL early_a1: pair=%b err=%b want pair=%b err=0", tmds_pair, sym_err, ea[3:2]);
      end
      tick();                                               // early load of B
      gb[1:0] = tmds_pair;
      n_cmp++;
      if (sym_err !== 1'b1) begin n_bad++; $display("FAIL early_err: got %b want 1", sym_err); end
      for (int p = 1; p < 5; p++) begin tick(); gb[2*p +: 2] = tmds_pair; end
      n_cmp++;
      if (gb !== eb) begin n_bad++; $display("FAIL early_sym_b: got %h want %h", gb, eb); end
   endtask

   task automatic test_enable();
      logic [9:0] e, g;
      do_reset();
      data = 8'($urandom); de = 1'b1;
      e = ref_sym(1'b1, data, 2'b00);
      pixel_stb = 1'b1; tick();
      pixel_stb = 1'b0; tick();
      tick(); g[1:0] = tmds_pair;
      tick(); g[3:2] = tmds_pair;
      // frozen: strobes while enable is low must also be ignored
      enable = 1'b0; pixel_stb = 1'b1; data = 8'($urandom);
      for (int i = 0; i < 7; i++) begin
         tick();
         n_cmp++;
         if (tmds_pair !== e[3:2]) begin n_bad++; $display("FAIL enable_hold[%0d]: got %b want %b", i, tmds_pair, e[3:2]); end
      end
      enable = 1'b1; pixel_stb = 1'b0;
      for (int p = 2; p < 5; p++) begin tick(); g[2*p +: 2] = tmds_pair; end
      n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL enable_resume_sym: got %h want %h", g, e); end
      n_cmp++;
      if (sym_err !== 1'b0) begin n_bad++; $display("FAIL enable_err: got %b want 0", sym_err); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      pix_de[0] = 1'b1; pix_data[0] = 8'h00; pix_ctrl[0] = 2'b00;
      stream(1);                                            // cnt now -8
      tick();                                               // underrun sets sym_err
      n_cmp++;
      if (sym_err !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_err: got %b want 1", sym_err); end
      de = 1'b1; data = 8'($urandom); pixel_stb = 1'b1; tick();
      pixel_stb = 1'b0; tick(); tick(); tick();             // mid-symbol, phase 1
      areset = 1'b1; tick();
      n_cmp++;
      if (tmds_pair !== 2'b00 || sym_err !== 1'b0) begin
         n_bad++; $display("FAIL midrst_out: pair=%b err=%b want pair=00 err=0", tmds_pair, sym_err);
      end
      areset = 1'b0;
      stream(1);                                            // cnt = 0 again: 0x00 -> 0x100
      n_cmp++;
      if (got[0] !== 10'h100) begin n_bad++; $display("FAIL midrst_cnt0: got %h want 100", got[0]); end
      n_cmp++;
      if (sym_err !== 1'b0) begin n_bad++; $display("FAIL midrst_err: got %b want 0", sym_err); end
   endtask

   initial begin
      areset = 1'b1; enable = 1'b0; pixel_stb = 1'b0; de = 1'b0; data = '0; ctrl = '0;
      test_reset();
      test_data_00();
      test_data_ff();
      test_control();
      test_random();
      test_underrun();
      test_early();
      test_enable();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
